fabric_cpu_bridge: RTL and testbench

CPU-side end of the CPU↔fabric operand/result interface of the eastern CPU IO tile column. Accepts one custom-instruction request (two 32-bit operands) from the CPU over a valid/ready handshake and drives the operands onto the tiles' OPA/OPB pins. After a per-request programmable fabric latency it captures the 96 result bits from the tiles' RES0/RES1/RES2 pins and returns them over a valid/ready response channel. One transaction is in flight at a time.

---
 rtl/fabric_cpu_bridge_pkg.sv | 27 ++
 rtl/fabric_latency_counter.sv | 31 +++
 rtl/fabric_cpu_bridge.sv | 98 +++++++++
 tb/tb_fabric_cpu_bridge.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cpu_bridge_pkg.sv
// Shared types and constants for the CPU-side fabric operand/result bridge
// and for tile-level wrappers that slice the column-wide OPA/OPB/RES buses.
package fabric_cpu_bridge_pkg;

  localparam int NumTilesDefault = 8;
  localparam int LatWidthDefault = 4;

  // Each CPU IO tile contributes this many bits to every operand/result port.
  localparam int BitsPerTile = 4;

  // Two-bit state register; IDLE must encode as zero.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit bounds of tile t's slice within a column-wide bus.
  function automatic int tile_lsb(input int t);
    return t * BitsPerTile;
  endfunction

  function automatic int tile_msb(input int t);
    return t * BitsPerTile + BitsPerTile - 1;
  endfunction

endpackage

// File: rtl/fabric_latency_counter.sv
// Per-request fabric latency counter: loads L on accept, counts down while
// the bridge waits, flags done at zero and never wraps below zero.
module fabric_latency_counter #(
  parameter int LatWidth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [LatWidth-1:0] load_value,
  input  logic                dec,
  output logic                done
);

  logic [LatWidth-1:0] cnt;

  // Load on accept, decrement while waiting, saturate at zero.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so every flop samples the
    // pre-edge value of the others, independent of statement order.
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/fabric_cpu_bridge.sv
// CPU-side end of the CPU<->fabric operand/result interface. Accepts one
// two-operand request, drives the tile OPA/OPB pins, waits the requested
// number of extra fabric cycles, captures RES0/1/2 and returns them.
// Only one transaction is ever in flight.
module fabric_cpu_bridge
  import fabric_cpu_bridge_pkg::*;
#(
  parameter int NumTiles  = NumTilesDefault,
  parameter int DataWidth = BitsPerTile * NumTiles,
  parameter int LatWidth  = LatWidthDefault
) (
  input  logic                 UserCLK,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DataWidth-1:0] req_opa,
  input  logic [DataWidth-1:0] req_opb,
  input  logic [LatWidth-1:0]  req_latency,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_res0,
  output logic [DataWidth-1:0] rsp_res1,
  output logic [DataWidth-1:0] rsp_res2,
  output logic                 busy,
  output logic [DataWidth-1:0] OPA,
  output logic [DataWidth-1:0] OPB,
  input  logic [DataWidth-1:0] RES0,
  input  logic [DataWidth-1:0] RES1,
  input  logic [DataWidth-1:0] RES2
);

  state_e state;
  logic   accept;
  logic   lat_done;

  // Handshake flags decode straight from the state register, so req_ready
  // is already low on the edge that completes a response handshake.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;

  fabric_latency_counter #(
    .LatWidth(LatWidth)
  ) u_latency (
    .clk       (UserCLK),
    .reset     (reset),
    .load      (accept),
    .load_value(req_latency),
    .dec       (state == WAIT),
    .done      (lat_done)
  );

  // Transaction FSM with registered operand, result and rsp_valid outputs.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      // NOTE: a mid-transaction reset deliberately clears the operand and
      // result registers too, so no stale pending result can resurface.
      state     <= IDLE;
      OPA       <= '0;
      OPB       <= '0;
      rsp_valid <= 1'b0;
      rsp_res0  <= '0;
      rsp_res1  <= '0;
      rsp_res2  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Operands persist on the tile pins until the next accept.
          if (req_valid) begin
            OPA   <= req_opa;
            OPB   <= req_opb;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_done) begin
            rsp_res0  <= RES0;
            rsp_res1  <= RES1;
            rsp_res2  <= RES2;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          // Results stay readable after the handshake; only rsp_valid drops.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_cpu_bridge.sv
// Self-checking bench for fabric_cpu_bridge. Expected responses are pushed
// into a scoreboard queue when a request is driven and popped when the
// bridge raises rsp_valid.
module tb_fabric_cpu_bridge;

  localparam int DW = 32;
  localparam int LW = 4;

  typedef logic [3*DW-1:0] rsp_t;  // {res0, res1, res2}

  logic          UserCLK;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_opa;
  logic [DW-1:0] req_opb;
  logic [LW-1:0] req_latency;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_res0;
  logic [DW-1:0] rsp_res1;
  logic [DW-1:0] rsp_res2;
  logic          busy;
  logic [DW-1:0] OPA;
  logic [DW-1:0] OPB;
  logic [DW-1:0] RES0;
  logic [DW-1:0] RES1;
  logic [DW-1:0] RES2;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  fabric_cpu_bridge dut (
    .UserCLK    (UserCLK),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .req_latency(req_latency),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res0   (rsp_res0),
    .rsp_res1   (rsp_res1),
    .rsp_res2   (rsp_res2),
    .busy       (busy),
    .OPA        (OPA),
    .OPB        (OPB),
    .RES0       (RES0),
    .RES1       (RES1),
    .RES2       (RES2)
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  // Edge counter: after the n-th rising edge, cyc == n.
  always @(posedge UserCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; all sampling happens here.
  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Bounded wait for rsp_valid; no comparisons here.
  task automatic wait_rsp(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opa = '0; req_opb = '0; req_latency = '0;
    RES0 = '0; RES1 = '0; RES2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/busy/valid=%b want 100", {req_ready, busy, rsp_valid});
    end
    n_checks++;
    if ({OPA, OPB} !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: got OPA=%h OPB=%h want 0", OPA, OPB);
    end
    n_checks++;
    if ({rsp_res0, rsp_res1, rsp_res2} !== '0) begin
      n_fail++;
      $display("FAIL reset_results: got %h %h %h want 0", rsp_res0, rsp_res1, rsp_res2);
    end
  endtask

  task automatic test_basic_l0();
    rsp_t exp;
    RES0 = 32'hAAAA5555; RES1 = 32'h0F0F0F0F; RES2 = 32'hDEADBEEF;
    req_opa = 32'h12345678; req_opb = 32'h9ABCDEF0; req_latency = 4'd0;
    req_valid = 1'b1;
    sb.push_back({RES0, RES1, RES2});
    tick();  // accept edge k
    req_valid = 1'b0;
    n_checks++;
    if (OPA !== 32'h12345678 || OPB !== 32'h9ABCDEF0) begin
      n_fail++;
      $display("FAIL basic_operands: got OPA=%h OPB=%h want 12345678 9abcdef0", OPA, OPB);
    end
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_after_accept: got ready/busy/valid=%b want 010", {req_ready, busy, rsp_valid});
    end
    tick();  // edge k+1
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: rsp_valid=%b one cycle after accept, want 1", rsp_valid);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL basic_result: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
        n_fail++;
        $display("FAIL basic_result: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();  // handshake
    rsp_ready = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10 || {rsp_res0, rsp_res1, rsp_res2} !== exp) begin
      n_fail++;
      $display("FAIL basic_handshake: ready/valid=%b res=%h %h %h want 10 and held results",
               {req_ready, rsp_valid}, rsp_res0, rsp_res1, rsp_res2);
    end
  endtask

  task automatic test_long_latency();
    rsp_t exp;
    int   k;
    req_opa = 32'h0BADF00D; req_opb = 32'h00C0FFEE; req_latency = 4'd15;
    RES1 = 32'h11111111; RES2 = 32'h22222222;
    RES0 = 32'(cyc + 1);
    req_valid = 1'b1;
    tick();  // accept edge k
    req_valid = 1'b0;
    k = cyc;
    sb.push_back({32'(k + 16), RES1, RES2});
    for (int i = 1; i <= 15; i++) begin
      RES0 = 32'(cyc + 1);
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL long_early_valid: rsp_valid=%b at k+%0d want 0", rsp_valid, i);
      end
    end
    RES0 = 32'(cyc + 1);
    tick();  // edge k+16
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL long_valid: rsp_valid=%b at k+16 want 1", rsp_valid);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL long_result: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
        n_fail++;
        $display("FAIL long_result: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    rsp_t exp;
    bit   ok;
    RES0 = 32'h01010101; RES1 = 32'h02020202; RES2 = 32'h03030303;
    req_opa = 32'hA1A1A1A1; req_opb = 32'hB1B1B1B1; req_latency = 4'd1;
    req_valid = 1'b1;
    sb.push_back({RES0, RES1, RES2});
    tick();  // accept first
    req_opa = 32'hA2A2A2A2; req_opb = 32'hB2B2B2B2; req_latency = 4'd0;
    wait_rsp(5, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: no response within 5 cycles");
    end
    exp = '0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_result: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
        n_fail++;
        $display("FAIL bp_result: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
      end
    end
    RES0 = 32'h04040404; RES1 = 32'h05050505; RES2 = 32'h06060606;
    sb.push_back({RES0, RES1, RES2});
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || OPA !== 32'hA1A1A1A1 ||
          {rsp_res0, rsp_res1, rsp_res2} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b OPA=%h res=%h %h %h want 1 0 a1a1a1a1 %h",
                 i, rsp_valid, req_ready, OPA, rsp_res0, rsp_res1, rsp_res2, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();  // handshake edge h
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01 || OPA !== 32'hA1A1A1A1) begin
      n_fail++;
      $display("FAIL bp_handshake: valid/ready=%b OPA=%h want 01 a1a1a1a1", {rsp_valid, req_ready}, OPA);
    end
    tick();  // edge h+1 accepts the pending request
    req_valid = 1'b0;
    n_checks++;
    if (OPA !== 32'hA2A2A2A2 || OPB !== 32'hB2B2B2B2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_accept: OPA=%h OPB=%h busy=%b want a2a2a2a2 b2b2b2b2 1", OPA, OPB, busy);
    end
    wait_rsp(5, ok);
    n_checks++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_second_result: response ok=%b queue=%0d", ok, sb.size());
    end else begin
      exp = sb.pop_front();
      if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
        n_fail++;
        $display("FAIL bp_second_result: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rsp_t          exp;
    logic [DW-1:0] cur_opa;
    logic [DW-1:0] acc_opa;
    logic [DW-1:0] acc_opb;
    logic          pre;
    int            last_acc;
    int            n_acc;
    cur_opa = 32'hC0DE0000; acc_opa = '0; acc_opb = '0;
    last_acc = -1; n_acc = 0;
    RES1 = 32'h5A5A5A5A; RES2 = 32'hA5A5A5A5;
    req_opa = cur_opa; req_opb = ~cur_opa; req_latency = 4'd2;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pre = req_ready;
      tick();
      if (rsp_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_result: unexpected response %h", rsp_res0);
        end else begin
          exp = sb.pop_front();
          if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
          end
        end
      end
      if (pre) begin
        n_acc++;
        n_checks++;
        if (OPA !== cur_opa || OPB !== ~cur_opa) begin
          n_fail++;
          $display("FAIL b2b_operands: OPA=%h OPB=%h want %h %h", OPA, OPB, cur_opa, ~cur_opa);
        end
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 5) begin
            n_fail++;
            $display("FAIL b2b_period: accept spacing %0d want 5", cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_opa  = cur_opa;
        acc_opb  = ~cur_opa;
        RES0     = cur_opa ^ 32'hFFFF0000;
        sb.push_back({RES0, RES1, RES2});
        cur_opa  = cur_opa + 32'd1;
        req_opa  = cur_opa;
        req_opb  = ~cur_opa;
      end else if (n_acc > 0) begin
        n_checks++;
        if (OPA !== acc_opa || OPB !== acc_opb) begin
          n_fail++;
          $display("FAIL b2b_persist: OPA=%h OPB=%h want %h %h", OPA, OPB, acc_opa, acc_opb);
        end
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      tick();
      if (rsp_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
          n_fail++;
          $display("FAIL b2b_drain: got %h %h %h want %h", rsp_res0, rsp_res1, rsp_res2, exp);
        end
      end
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (n_acc != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d pending=%0d want 4 0", n_acc, sb.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    req_opa = 32'h77777777; req_opb = 32'h88888888; req_latency = 4'd7;
    RES0 = 32'hFEEDFACE; RES1 = 32'hFEEDFACE; RES2 = 32'hFEEDFACE;
    req_valid = 1'b1;
    tick();  // accept, cnt = 7
    req_valid = 1'b0;
    repeat (4) tick();  // cnt = 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100 || OPA !== '0 || OPB !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: ready/busy/valid=%b OPA=%h OPB=%h want 100 0 0",
               {req_ready, busy, rsp_valid}, OPA, OPB);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_no_response: responses seen %0d want 0", seen);
    end
  endtask

  task automatic test_tile_map();
    rsp_t          exp;
    logic [DW-1:0] want;
    logic [DW-1:0] mask;
    rsp_ready = 1'b1;
    req_opb = '0; req_latency = 4'd0;
    for (int t = 0; t < 8; t++) begin
      want = 32'h1 << (4 * t);
      mask = 32'hF << (4 * t);
      req_opa = want;
      RES0 = want; RES1 = ~want; RES2 = 32'(t);
      sb.push_back({RES0, RES1, RES2});
      req_valid = 1'b1;
      tick();  // accept
      req_valid = 1'b0;
      n_checks++;
      if (OPA[4*t +: 4] !== 4'h1 || (OPA & ~mask) !== '0) begin
        n_fail++;
        $display("FAIL tile_map: tile %0d OPA=%h want %h", t, OPA, want);
      end
      tick();  // capture
      n_checks++;
      if (!rsp_valid || sb.size() == 0) begin
        n_fail++;
        $display("FAIL tile_result: tile %0d rsp_valid=%b queue=%0d", t, rsp_valid, sb.size());
      end else begin
        exp = sb.pop_front();
        if ({rsp_res0, rsp_res1, rsp_res2} !== exp) begin
          n_fail++;
          $display("FAIL tile_result: tile %0d got %h %h %h want %h", t, rsp_res0, rsp_res1, rsp_res2, exp);
        end
      end
      tick();  // handshake
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_l0();
    test_long_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_tile_map();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
